// File: rtl/rob_retire.sv
// rob_retire: in-order reorder buffer; one allocation, one completion and one retire per cycle.
// Define ROB_STATS_EN to build the free-running retired_count statistic.
module rob_retire #(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             STALL,
    input  logic             entry_allocate_ROB,
    input  logic [88:0]      entry_ROB,
    output logic [IDX_W-1:0] rob_tail_idx,
    output logic             rob_halt,
    input  logic             complete_valid,
    input  logic [IDX_W-1:0] complete_idx,
    output logic             retire_valid,
    output logic [31:0]      retire_instr,
    output logic [31:0]      retire_pc,
    output logic [5:0]       retire_map,
    output logic             retire_regwr,
    output logic             retire_st,
    output logic             rob_overflow,
    output logic [31:0]      retired_count
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] HALT_CNT = (IDX_W+1)'(DEPTH - 1);

    logic [88:0]      payload_q [DEPTH];
    logic [88:0]      payload_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;

    logic             retire_valid_q, retire_valid_d;
    logic [31:0]      retire_instr_q, retire_instr_d;
    logic [31:0]      retire_pc_q, retire_pc_d;
    logic [5:0]       retire_map_q, retire_map_d;
    logic             retire_regwr_q, retire_regwr_d;
    logic             retire_st_q, retire_st_d;
    logic             overflow_q, overflow_d;

    logic             alloc_ok;
    logic             do_retire;

    always_comb begin
        alloc_ok  = entry_allocate_ROB && (count_q < FULL_CNT);
        do_retire = (count_q != '0) && valid_q[head_q] && done_q[head_q] && !STALL && !FLUSH;
    end

    always_comb begin
        payload_d      = payload_q;
        valid_d        = valid_q;
        done_d         = done_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        retire_valid_d = 1'b0;
        retire_instr_d = retire_instr_q;
        retire_pc_d    = retire_pc_q;
        retire_map_d   = retire_map_q;
        retire_regwr_d = retire_regwr_q;
        retire_st_d    = retire_st_q;
        overflow_d     = overflow_q;

        if (FLUSH) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (complete_valid && valid_q[complete_idx]) begin
                done_d[complete_idx] = 1'b1;
            end
            if (do_retire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + IDX_W'(1);
                retire_valid_d  = 1'b1;
                retire_instr_d  = payload_q[head_q][88:57];
                retire_pc_d     = payload_q[head_q][56:25];
                retire_map_d    = payload_q[head_q][17:12];
                retire_regwr_d  = payload_q[head_q][23] | payload_q[head_q][22];
                retire_st_d     = payload_q[head_q][21];
            end
            // Allocation is applied last so it wins over a completion aimed at the tail slot.
            if (alloc_ok) begin
                payload_d[tail_q] = entry_ROB;
                valid_d[tail_q]   = 1'b1;
                done_d[tail_q]    = 1'b0;
                tail_d            = tail_q + IDX_W'(1);
            end else if (entry_allocate_ROB) begin
                overflow_d = 1'b1;
            end
            case ({alloc_ok, do_retire})
                2'b10:   count_d = count_q + (IDX_W+1)'(1);
                2'b01:   count_d = count_q - (IDX_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        payload_q <= payload_d;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q        <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            retire_valid_q <= 1'b0;
            retire_instr_q <= '0;
            retire_pc_q    <= '0;
            retire_map_q   <= '0;
            retire_regwr_q <= 1'b0;
            retire_st_q    <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            done_q         <= done_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            retire_valid_q <= retire_valid_d;
            retire_instr_q <= retire_instr_d;
            retire_pc_q    <= retire_pc_d;
            retire_map_q   <= retire_map_d;
            retire_regwr_q <= retire_regwr_d;
            retire_st_q    <= retire_st_d;
            overflow_q     <= overflow_d;
        end
    end

`ifdef ROB_STATS_EN
    logic [31:0] retired_count_q, retired_count_d;

    always_comb begin
        retired_count_d = retired_count_q + (do_retire ? 32'd1 : 32'd0);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            retired_count_q <= '0;
        end else begin
            retired_count_q <= retired_count_d;
        end
    end

    assign retired_count = retired_count_q;
`else
    assign retired_count = '0;
`endif

    assign rob_tail_idx = tail_q;
    assign rob_halt     = (count_q >= HALT_CNT);
    assign retire_valid = retire_valid_q;
    assign retire_instr = retire_instr_q;
    assign retire_pc    = retire_pc_q;
    assign retire_map   = retire_map_q;
    assign retire_regwr = retire_regwr_q;
    assign retire_st    = retire_st_q;
    assign rob_overflow = overflow_q;

endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire: scoreboard of allocated entries popped on each retire pulse.
`timescale 1ns/1ps
module tb_rob_retire;

    localparam int DEPTH = 32;
    localparam int IDX_W = 5;
    localparam logic [6:0] RW = 7'b0100000;
    localparam logic [6:0] LD = 7'b0010000;
    localparam logic [6:0] ST = 7'b0001000;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             FLUSH = 1'b0;
    logic             STALL = 1'b0;
    logic             entry_allocate_ROB = 1'b0;
    logic [88:0]      entry_ROB = '0;
    logic [IDX_W-1:0] rob_tail_idx;
    logic             rob_halt;
    logic             complete_valid = 1'b0;
    logic [IDX_W-1:0] complete_idx = '0;
    logic             retire_valid;
    logic [31:0]      retire_instr;
    logic [31:0]      retire_pc;
    logic [5:0]       retire_map;
    logic             retire_regwr;
    logic             retire_st;
    logic             rob_overflow;
    logic [31:0]      retired_count;

    rob_retire #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .STALL(STALL),
        .entry_allocate_ROB(entry_allocate_ROB), .entry_ROB(entry_ROB),
        .rob_tail_idx(rob_tail_idx), .rob_halt(rob_halt),
        .complete_valid(complete_valid), .complete_idx(complete_idx),
        .retire_valid(retire_valid), .retire_instr(retire_instr), .retire_pc(retire_pc),
        .retire_map(retire_map), .retire_regwr(retire_regwr), .retire_st(retire_st),
        .rob_overflow(rob_overflow), .retired_count(retired_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  map;
        logic        regwr;
        logic        st;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               seq = 0;
    int               n_alloc = 0;
    int               n_ret = 0;
    int               ret_base = 0;
    logic [IDX_W-1:0] m_tail = '0;

    function automatic logic [31:0] exp_rc();
`ifdef ROB_STATS_EN
        return 32'(n_ret - ret_base);
`else
        return 32'd0;
`endif
    endfunction

    // One cycle: consume any retire pulse against the scoreboard, then drop one-shot strobes.
    task automatic tick();
        exp_t e;
        @(negedge CLK);
        if (RESET && retire_valid) begin
            n_ret++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_retire: got map=%0d pc=%h, required no retire", retire_map, retire_pc);
            end else begin
                e = sb.pop_front();
                if ({retire_instr, retire_pc, retire_map, retire_regwr, retire_st} !==
                    {e.instr, e.pc, e.map, e.regwr, e.st}) begin
                    errors++;
                    $display("FAIL sb_retire: got instr=%h pc=%h map=%0d rw=%b st=%b, required instr=%h pc=%h map=%0d rw=%b st=%b",
                             retire_instr, retire_pc, retire_map, retire_regwr, retire_st,
                             e.instr, e.pc, e.map, e.regwr, e.st);
                end
            end
        end
        #1;
        entry_allocate_ROB = 1'b0;
        complete_valid     = 1'b0;
        FLUSH              = 1'b0;
    endtask

    task automatic do_alloc(input logic [5:0] map, input logic [6:0] ctrl);
        exp_t e;
        tick();
        e.instr = 32'hC0DE_0000 | 32'(seq);
        e.pc    = 32'h0000_4000 + 32'(seq) * 32'd4;
        e.map   = map;
        e.regwr = ctrl[5] | ctrl[4];
        e.st    = ctrl[3];
        entry_allocate_ROB = 1'b1;
        entry_ROB = {e.instr, e.pc, ctrl, map, 6'(seq), ~map};
        seq++;
        if (n_alloc - n_ret < DEPTH) begin
            sb.push_back(e);
            n_alloc++;
            m_tail = m_tail + 1'b1;
        end
    endtask

    task automatic do_complete(input logic [IDX_W-1:0] idx);
        tick();
        complete_valid = 1'b1;
        complete_idx   = idx;
    endtask

    task automatic wait_retires(input int target, input int budget);
        int k;
        k = 0;
        while (n_ret < target && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (n_ret < target) begin
            errors++;
            $display("FAIL wait_retires: got %0d retires, required %0d within %0d cycles", n_ret, target, budget);
        end
    endtask

    task automatic apply_reset();
        tick();
        RESET = 1'b0;
        STALL = 1'b0;
        repeat (2) tick();
        RESET    = 1'b1;
        sb.delete();
        n_alloc  = n_ret;
        ret_base = n_ret;
        m_tail   = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        tick();
        checks++;
        if ({retire_valid, retire_instr, retire_pc, retire_map, retire_regwr, retire_st, rob_overflow, rob_tail_idx, rob_halt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rv=%b instr=%h pc=%h map=%0d ovf=%b tail=%0d halt=%b, required all 0",
                     retire_valid, retire_instr, retire_pc, retire_map, rob_overflow, rob_tail_idx, rob_halt);
        end
        checks++;
        if (retired_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, required 0", retired_count);
        end
        for (int i = 1; i <= 6; i++) do_alloc(6'(i), RW);
        do_complete(0);
        wait_retires(n_ret + 1, 10);
        // count is now 5; drop reset asynchronously in mid-cycle
        @(negedge CLK);
        #3;
        RESET = 1'b0;
        #1;
        checks++;
        if ({retire_valid, retire_instr, retire_pc, retire_map, retire_regwr, retire_st, rob_overflow, rob_tail_idx, rob_halt} !== '0) begin
            errors++;
            $display("FAIL async_reset: got rv=%b instr=%h pc=%h map=%0d rw=%b st=%b tail=%0d halt=%b, required all 0",
                     retire_valid, retire_instr, retire_pc, retire_map, retire_regwr, retire_st, rob_tail_idx, rob_halt);
        end
        checks++;
        if (retired_count !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_count: got %0d, required 0", retired_count);
        end
        tick();
        RESET    = 1'b1;
        sb.delete();
        n_alloc  = n_ret;
        ret_base = n_ret;
        m_tail   = '0;
    endtask

    task automatic test_order();
        int r0;
        r0 = n_ret;
        do_alloc(6'd33, RW);
        do_alloc(6'd34, RW);
        do_alloc(6'd35, RW);
        do_complete(1);
        repeat (3) tick();
        checks++;
        if (n_ret !== r0) begin
            errors++;
            $display("FAIL order_blocked: got %0d retires, required 0", n_ret - r0);
        end
        do_complete(0);
        tick();
        checks++;
        if (retire_valid !== 1'b0) begin
            errors++;
            $display("FAIL order_latency: got retire_valid=%b, required 0", retire_valid);
        end
        tick();
        checks++;
        if (retire_valid !== 1'b1 || retire_map !== 6'd33) begin
            errors++;
            $display("FAIL order_first: got rv=%b map=%0d, required rv=1 map=33", retire_valid, retire_map);
        end
        tick();
        checks++;
        if (retire_valid !== 1'b1 || retire_map !== 6'd34) begin
            errors++;
            $display("FAIL order_second: got rv=%b map=%0d, required rv=1 map=34", retire_valid, retire_map);
        end
        tick();
        checks++;
        if (retire_valid !== 1'b0 || rob_tail_idx !== m_tail) begin
            errors++;
            $display("FAIL order_pending: got rv=%b tail=%0d, required rv=0 tail=%0d", retire_valid, rob_tail_idx, m_tail);
        end
        do_complete(2);
        wait_retires(r0 + 3, 10);
        checks++;
        if (retire_map !== 6'd35) begin
            errors++;
            $display("FAIL order_third: got map=%0d, required 35", retire_map);
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 30; i++) do_alloc(6'(i), RW);
        tick();
        checks++;
        if (rob_halt !== 1'b0 || rob_tail_idx !== 5'd30) begin
            errors++;
            $display("FAIL full_30: got halt=%b tail=%0d, required halt=0 tail=30", rob_halt, rob_tail_idx);
        end
        do_alloc(6'd30, RW);
        tick();
        checks++;
        if (rob_halt !== 1'b1 || rob_tail_idx !== 5'd31) begin
            errors++;
            $display("FAIL full_31: got halt=%b tail=%0d, required halt=1 tail=31", rob_halt, rob_tail_idx);
        end
        do_alloc(6'd31, RW);
        tick();
        checks++;
        if (rob_halt !== 1'b1 || rob_tail_idx !== 5'd0 || rob_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_32: got halt=%b tail=%0d ovf=%b, required halt=1 tail=0 ovf=0", rob_halt, rob_tail_idx, rob_overflow);
        end
        do_alloc(6'd63, RW);
        tick();
        checks++;
        if (rob_overflow !== 1'b1 || rob_tail_idx !== 5'd0) begin
            errors++;
            $display("FAIL overflow_set: got ovf=%b tail=%0d, required ovf=1 tail=0", rob_overflow, rob_tail_idx);
        end
        repeat (2) tick();
        checks++;
        if (rob_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b, required 1", rob_overflow);
        end
    endtask

    task automatic test_wrap();
        int r0;
        r0 = n_ret;
        for (int i = 0; i < 8; i++) do_complete(IDX_W'(i));
        wait_retires(r0 + 8, 20);
        for (int i = 0; i < 8; i++) do_alloc(6'(40 + i), RW);
        tick();
        checks++;
        if (rob_tail_idx !== 5'd8 || rob_halt !== 1'b1) begin
            errors++;
            $display("FAIL wrap_tail: got tail=%0d halt=%b, required tail=8 halt=1", rob_tail_idx, rob_halt);
        end
        do_complete(3);
        repeat (3) tick();
        checks++;
        if (n_ret !== r0 + 8) begin
            errors++;
            $display("FAIL wrap_inorder: got %0d retires, required 8", n_ret - r0);
        end
        for (int i = 8; i < 32; i++) do_complete(IDX_W'(i));
        for (int i = 0; i < 3; i++) do_complete(IDX_W'(i));
        wait_retires(r0 + 36, 20);
        repeat (3) tick();
        checks++;
        if (n_ret !== r0 + 36 || retire_valid !== 1'b0 || retire_map !== 6'd43) begin
            errors++;
            $display("FAIL wrap_drain: got retires=%0d rv=%b map=%0d, required retires=36 rv=0 map=43",
                     n_ret - r0, retire_valid, retire_map);
        end
        checks++;
        if (retired_count !== exp_rc()) begin
            errors++;
            $display("FAIL wrap_count: got %0d, required %0d", retired_count, exp_rc());
        end
    endtask

    task automatic test_flush();
        logic [31:0] rc_before;
        int r0;
        for (int i = 0; i < 6; i++) do_alloc(6'(50 + i), RW);
        tick();
        checks++;
        if (rob_halt !== 1'b0 || rob_tail_idx !== 5'd14) begin
            errors++;
            $display("FAIL flush_pre: got halt=%b tail=%0d, required halt=0 tail=14", rob_halt, rob_tail_idx);
        end
        rc_before = exp_rc();
        do_complete(4);
        tick();
        FLUSH              = 1'b1;
        entry_allocate_ROB = 1'b1;
        entry_ROB          = {89{1'b1}};
        complete_valid     = 1'b1;
        complete_idx       = 5'd5;
        sb.delete();
        n_alloc = n_ret;
        m_tail  = '0;
        r0      = n_ret;
        tick();
        checks++;
        if (retire_valid !== 1'b0 || rob_tail_idx !== 5'd0 || rob_halt !== 1'b0 || rob_overflow !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: got rv=%b tail=%0d halt=%b ovf=%b, required rv=0 tail=0 halt=0 ovf=1",
                     retire_valid, rob_tail_idx, rob_halt, rob_overflow);
        end
        checks++;
        if (retired_count !== rc_before) begin
            errors++;
            $display("FAIL flush_count: got %0d, required %0d", retired_count, rc_before);
        end
        do_alloc(6'd7, RW);
        do_complete(0);
        wait_retires(r0 + 1, 10);
        tick();
        checks++;
        if (retire_map !== 6'd7 || rob_tail_idx !== 5'd1 || n_ret !== r0 + 1) begin
            errors++;
            $display("FAIL flush_after: got map=%0d tail=%0d retires=%0d, required map=7 tail=1 retires=1",
                     retire_map, rob_tail_idx, n_ret - r0);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        do_alloc(6'd9, ST);
        do_complete(0);
        STALL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (retire_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got retire_valid=%b, required 0", i, retire_valid);
            end
        end
        STALL = 1'b0;
        tick();
        checks++;
        if (retire_valid !== 1'b1 || retire_st !== 1'b1 || retire_regwr !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got rv=%b st=%b rw=%b, required rv=1 st=1 rw=0", retire_valid, retire_st, retire_regwr);
        end
        do_alloc(6'd12, LD);
        do_complete(1);
        wait_retires(n_ret + 1, 10);
        checks++;
        if (retire_regwr !== 1'b1 || retire_st !== 1'b0 || retire_map !== 6'd12) begin
            errors++;
            $display("FAIL load_regwr: got rw=%b st=%b map=%0d, required rw=1 st=0 map=12", retire_regwr, retire_st, retire_map);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_alloc(6'd20, RW);
        do_alloc(6'd21, RW);
        complete_valid = 1'b1;
        complete_idx   = 5'd0;
        do_alloc(6'd22, RW);
        tick();
        checks++;
        if (retire_valid !== 1'b1 || retire_map !== 6'd20 || rob_tail_idx !== 5'd3) begin
            errors++;
            $display("FAIL b2b_retire: got rv=%b map=%0d tail=%0d, required rv=1 map=20 tail=3", retire_valid, retire_map, rob_tail_idx);
        end
        // count should be 2 now; 28 more reach 30 (no halt), one more reaches 31
        for (int i = 0; i < 28; i++) do_alloc(6'(i), RW);
        tick();
        checks++;
        if (rob_halt !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count30: got halt=%b, required 0", rob_halt);
        end
        do_alloc(6'd60, RW);
        tick();
        checks++;
        if (rob_halt !== 1'b1 || rob_tail_idx !== m_tail) begin
            errors++;
            $display("FAIL b2b_count31: got halt=%b tail=%0d, required halt=1 tail=%0d", rob_halt, rob_tail_idx, m_tail);
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full();
        test_wrap();
        test_flush();
        test_stall();
        test_back_to_back();
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
